// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage: NOP encoding,
// fetch FSM states and PC stepping constants.
package instruction_fetch_pkg;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam int          PC_INC        = 4;
  localparam int          PC_ALIGN_MASK = 3;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_pc_register.sv
// PC register: synchronous reset to RESET_PC, then load > increment > hold.
module pc_register
  import instruction_fetch_pkg::*;
#(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                inc,
  input  logic [PC_WIDTH-1:0] load_val,
  output logic [PC_WIDTH-1:0] pc
);

  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_q;

  // Increment wraps modulo 2^PC_WIDTH by plain truncation.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + PC_WIDTH'(PC_INC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: FILL/RUN/HOLD control over a synchronous-read imem.
// Optional macro IFETCH_MISALIGN_CHECK_EN adds the misaligned output.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_en,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                instr_valid
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic                misaligned
`endif
);

  fetch_state_e        state_d, state_q;
  logic [PC_WIDTH-1:0] fetch_pc_d, fetch_pc_q;
  logic [PC_WIDTH-1:0] pc_out_d, pc_out_q;
  logic [31:0]         instr_d, instr_q;
  logic                instr_valid_d, instr_valid_q;
  logic                misaligned_d, misaligned_q;
  logic                redirect;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] pc;
  logic                pc_load;
  logic                pc_inc;

  pc_register #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (target),
    .pc       (pc)
  );

  // A misaligned redirect is dropped and the cycle behaves as if no branch came.
  always_comb begin
`ifdef IFETCH_MISALIGN_CHECK_EN
    misaligned_d = branch_taken && (branch_target[1:0] != 2'b00);
    redirect     = branch_taken && !misaligned_d;
    target       = branch_target;
`else
    misaligned_d = 1'b0;
    redirect     = branch_taken;
    target       = branch_target & ~PC_WIDTH'(PC_ALIGN_MASK);
`endif
  end

  assign imem_addr = pc;
  assign imem_en   = !stall || redirect;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pc_out_d      = pc_out_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;
    if (redirect) begin
      pc_load       = 1'b1;
      instr_d       = NOP_INSTR;
      instr_valid_d = 1'b0;
      state_d       = ST_FILL;
    end else if (stall) begin
      // Memory is disabled, so imem_rdata keeps the word for fetch_pc.
      if (state_q != ST_FILL) begin
        state_d = ST_HOLD;
      end
    end else begin
      case (state_q)
        ST_FILL: begin
          pc_inc     = 1'b1;
          fetch_pc_d = pc;
          state_d    = ST_RUN;
        end
        ST_RUN, ST_HOLD: begin
          instr_d       = imem_rdata;
          pc_out_d      = fetch_pc_q;
          instr_valid_d = 1'b1;
          fetch_pc_d    = pc;
          pc_inc        = 1'b1;
          state_d       = ST_RUN;
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FILL;
      fetch_pc_q    <= RESET_PC;
      pc_out_q      <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pc_out_q      <= pc_out_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = instr_valid_q;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign misaligned = misaligned_q;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table plus random traffic
// checked against an instruction-stream model.
module tb_instruction_fetch;

  localparam int          PC_WIDTH = 8;
  localparam logic [7:0]  RESET_PC = 8'd0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic [7:0]  pc_out;
  logic        instr_valid;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  always #5 clk = ~clk;

  instruction_fetch #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_en       (imem_en),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid)
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    .misaligned    (misaligned)
`endif
  );

  // Memory holds word[i] = i at byte address 4*i.
  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {26'd0, a[7:2]};
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= word_at(imem_addr);
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Stream model: after a reset or redirect, one bubble cycle of non-stalled
  // progress precedes the first word; then each non-stalled cycle emits the
  // next sequential address and its memory word.
  bit          m_known = 1'b0;
  bit          m_bubble;
  logic [7:0]  m_next;
  logic [7:0]  m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic        m_mis;

  task automatic step(input logic r, input logic s, input logic b, input logic [7:0] t);
    logic       take;
    logic       bad;
    logic [7:0] exp_addr;
    rst = r; stall = s; branch_taken = b; branch_target = t;
    bad = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
    bad = b && (t[1:0] != 2'b00);
`endif
    take = b && !bad;
    #1;
    chk("imem_en", {31'd0, imem_en}, {31'd0, (!s || take)});
    if (m_known) begin
      exp_addr = m_bubble ? m_next : m_next + 8'd4;
      chk("imem_addr", {24'd0, imem_addr}, {24'd0, exp_addr});
    end
    @(posedge clk);
    cyc++;
    if (r) begin
      m_known = 1'b1; m_bubble = 1'b1; m_next = RESET_PC;
      m_pc = RESET_PC; m_valid = 1'b0; m_instr = NOP; m_mis = 1'b0;
    end else begin
      m_mis = bad;
      if (take) begin
        m_next = t & 8'hFC; m_bubble = 1'b1; m_valid = 1'b0; m_instr = NOP;
      end else if (!s) begin
        if (m_bubble) begin
          m_bubble = 1'b0;
        end else begin
          m_valid = 1'b1; m_pc = m_next; m_instr = word_at(m_next);
          m_next = m_next + 8'd4;
        end
      end
    end
    #1;
    if (m_known) begin
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      chk("pc_out", {24'd0, pc_out}, {24'd0, m_pc});
      chk("instr", instr, m_instr);
`ifdef IFETCH_MISALIGN_CHECK_EN
      chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
`endif
    end
  endtask

  typedef struct {
    logic       r;
    logic       s;
    logic       b;
    logic [7:0] t;
    logic       ev;
    logic [7:0] ep;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic s, input logic b,
                              input logic [7:0] t, input logic ev, input logic [7:0] ep);
    vec_t v;
    v.r = r; v.s = s; v.b = b; v.t = t; v.ev = ev; v.ep = ep;
    vecs.push_back(v);
  endfunction

  initial begin
    logic       r, s, b;
    logic [7:0] t;
    // reset and sequential start
    add(1, 0, 0, 8'd0,   0, 8'd0);
    add(0, 0, 0, 8'd0,   0, 8'd0);
    add(0, 0, 0, 8'd0,   1, 8'd0);
    add(0, 0, 0, 8'd0,   1, 8'd4);
    add(0, 0, 0, 8'd0,   1, 8'd8);
    // three-cycle stall at pc_out=8
    add(0, 1, 0, 8'd0,   1, 8'd8);
    add(0, 1, 0, 8'd0,   1, 8'd8);
    add(0, 1, 0, 8'd0,   1, 8'd8);
    add(0, 0, 0, 8'd0,   1, 8'd12);
    add(0, 0, 0, 8'd0,   1, 8'd16);
    // branch to 80
    add(0, 0, 1, 8'd80,  0, 8'd16);
    add(0, 0, 0, 8'd0,   0, 8'd16);
    add(0, 0, 0, 8'd0,   1, 8'd80);
    add(0, 0, 0, 8'd0,   1, 8'd84);
    // branch together with stall, stall lingering during fill
    add(0, 1, 1, 8'd40,  0, 8'd84);
    add(0, 1, 0, 8'd0,   0, 8'd84);
    add(0, 0, 0, 8'd0,   0, 8'd84);
    add(0, 0, 0, 8'd0,   1, 8'd40);
    add(0, 0, 0, 8'd0,   1, 8'd44);
    // wrap past the top of the address space
    add(0, 0, 1, 8'd244, 0, 8'd44);
    add(0, 0, 0, 8'd0,   0, 8'd44);
    add(0, 0, 0, 8'd0,   1, 8'd244);
    add(0, 0, 0, 8'd0,   1, 8'd248);
    add(0, 0, 0, 8'd0,   1, 8'd252);
    add(0, 0, 0, 8'd0,   1, 8'd0);
    add(0, 0, 0, 8'd0,   1, 8'd4);
    // misaligned target 82
`ifdef IFETCH_MISALIGN_CHECK_EN
    add(0, 0, 1, 8'd82,  1, 8'd8);
    add(0, 0, 0, 8'd0,   1, 8'd12);
    add(0, 0, 0, 8'd0,   1, 8'd16);
`else
    add(0, 0, 1, 8'd82,  0, 8'd4);
    add(0, 0, 0, 8'd0,   0, 8'd4);
    add(0, 0, 0, 8'd0,   1, 8'd80);
`endif
    // mid-stream reset
    add(1, 0, 0, 8'd0,   0, 8'd0);
    add(0, 0, 0, 8'd0,   0, 8'd0);
    add(0, 0, 0, 8'd0,   1, 8'd0);
    add(0, 0, 0, 8'd0,   1, 8'd4);
    // branch arriving while in HOLD
    add(0, 1, 0, 8'd0,   1, 8'd4);
    add(0, 1, 1, 8'd100, 0, 8'd4);
    add(0, 0, 0, 8'd0,   0, 8'd4);
    add(0, 0, 0, 8'd0,   1, 8'd100);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].s, vecs[i].b, vecs[i].t);
      chk($sformatf("tbl%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("tbl%0d_pc_out", i), {24'd0, pc_out}, {24'd0, vecs[i].ep});
    end

    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 12);
      t = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      step(r, s, b, t);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
